// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu : load/store unit between the pipeline and a single-beat data bus.
//
// Accepts one load or store per request from IDLE, launches a registered bus
// request, waits in BUSY for a one-cycle ack, and spends one RESP cycle before
// returning to IDLE. Faulting requests (misaligned, illegal funct3, or read and
// write both high) raise a one-cycle err_o and never reach the bus.
//
// Optional feature: define LSU_TIMEOUT_EN to abort BUSY after TIMEOUT_CYC
// cycles without an ack. Without it, BUSY waits indefinitely.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   addr_i, w_data_i          effective byte address, store data
//   MemRead_i, MemWrite_i     load / store request
//   funct3_i                  access size and sign
//   mem_data_o                registered, extended load result
//   stall_o                   combinational pipeline freeze
//   err_o                     registered one-cycle fault pulse
//   bus_req_o .. bus_be_o     registered data-bus request payload
//   bus_rdata_i, bus_ack_i    bus read data and completion pulse
// -----------------------------------------------------------------------------
module lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] w_data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] mem_data_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        ld_q, ld_d;       // outstanding access is a load
    logic [2:0]  f3_q, f3_d;       // access size/sign for load extraction
    logic [1:0]  lo_q, lo_d;       // byte offset for load lane selection

    // Request decode
    logic f3_legal, aligned, valid, fault, timeout;

    always_comb begin
        f3_legal = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = MemRead_i;  // unsigned forms exist only for loads
            default:                f3_legal = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        case (funct3_i[1:0])
            2'b01:   aligned = ~addr_i[0];
            2'b10:   aligned = (addr_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign valid = (MemRead_i ^ MemWrite_i) & f3_legal & aligned;
    assign fault = (MemRead_i | MemWrite_i) & ~valid;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts completed BUSY cycles; fires at the end of the TIMEOUT_CYC-th one
    assign timeout = (state_q == S_BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == S_BUSY && !bus_ack_i && !timeout) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Load lane extraction from the bus read data
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;

    always_comb begin
        case (lo_q)
            2'd0:    rd_byte = bus_rdata_i[7:0];
            2'd1:    rd_byte = bus_rdata_i[15:8];
            2'd2:    rd_byte = bus_rdata_i[23:16];
            default: rd_byte = bus_rdata_i[31:24];
        endcase
        rd_half = lo_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {24'd0, rd_byte};
            3'b101:  ld_ext = {16'd0, rd_half};
            default: ld_ext = bus_rdata_i;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (valid) state_d = S_BUSY;
            S_BUSY:  if (bus_ack_i || timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        stall_o    = 1'b0;
        mem_data_d = mem_data_q;
        err_d      = 1'b0;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        ld_d       = ld_q;
        f3_d       = f3_q;
        lo_d       = lo_q;
        case (state_q)
            S_IDLE: begin
                stall_o = valid & ~rst_i;
                req_d   = 1'b0;
                we_d    = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                be_d    = '0;
                if (valid) begin
                    req_d  = 1'b1;
                    we_d   = MemWrite_i;
                    addr_d = {addr_i[31:2], 2'b00};
                    ld_d   = MemRead_i;
                    f3_d   = funct3_i;
                    lo_d   = addr_i[1:0];
                    be_d   = 4'hF;
                    if (MemWrite_i) begin
                        case (funct3_i[1:0])
                            2'b00: begin
                                wdata_d = {4{w_data_i[7:0]}};
                                be_d    = 4'b0001 << addr_i[1:0];
                            end
                            2'b01: begin
                                wdata_d = {2{w_data_i[15:0]}};
                                be_d    = 4'b0011 << {addr_i[1], 1'b0};
                            end
                            default: wdata_d = w_data_i;
                        endcase
                    end
                end else if (fault) begin
                    err_d      = 1'b1;
                    mem_data_d = '0;
                end
            end
            S_BUSY: begin
                stall_o = ~rst_i;
                if (bus_ack_i || timeout) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    be_d    = '0;
                    if (bus_ack_i) begin
                        if (ld_q) mem_data_d = ld_ext;
                    end else begin
                        err_d      = 1'b1;
                        mem_data_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and access context
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_data_q <= '0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            ld_q       <= 1'b0;
            f3_q       <= '0;
            lo_q       <= '0;
        end else begin
            mem_data_q <= mem_data_d;
            err_q      <= err_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            ld_q       <= ld_d;
            f3_q       <= f3_d;
            lo_q       <= lo_d;
        end
    end

    assign mem_data_o  = mem_data_q;
    assign err_o       = err_q;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_be_o    = be_q;

endmodule
